// File: rtl/control_unit.sv
// Sequencing FSM for the 8-register, 16-bit datapath: walks T0..T3 per instruction and
// decodes the IIIXXXYYY instruction into bus-source selects and register load enables.
module control_unit (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [8:0] IR,
    output logic       IRin,
    output logic [7:0] Rout,
    output logic       Gout,
    output logic       DINout,
    output logic [7:0] Rin,
    output logic       Ain,
    output logic       Gin,
    output logic [2:0] AluOp,
    output logic       Done
);
    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } tstep_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;

    tstep_e     Tstep_q, Tstep_d;
    logic [2:0] opcode, reg_x, reg_y;
    logic       is_alu;

    assign opcode = IR[8:6];
    assign reg_x  = IR[5:3];
    assign reg_y  = IR[2:0];
    assign is_alu = (opcode != OP_MV) && (opcode != OP_MVI);

    // Register k maps to bit (7-k): R0 is the MSB of the one-hot select.
    function automatic logic [7:0] sel(input logic [2:0] k);
        return 8'b1000_0000 >> k;
    endfunction

    always_comb begin
        Tstep_d = Tstep_q;
        IRin    = 1'b0;
        Rout    = 8'b0;
        Gout    = 1'b0;
        DINout  = 1'b0;
        Rin     = 8'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        AluOp   = 3'b000;
        Done    = 1'b0;
        case (Tstep_q)
            T0: begin
                IRin = Run;
                if (Run) Tstep_d = T1;
            end
            T1: begin
                if (opcode == OP_MV) begin
                    Rout    = sel(reg_y);
                    Rin     = sel(reg_x);
                    Done    = 1'b1;
                    Tstep_d = T0;
                end else if (opcode == OP_MVI) begin
                    DINout  = 1'b1;
                    Rin     = sel(reg_x);
                    Done    = 1'b1;
                    Tstep_d = T0;
                end else begin
                    Rout    = sel(reg_x);
                    Ain     = 1'b1;
                    Tstep_d = T2;
                end
            end
            T2: begin
                if (is_alu) begin
                    Rout    = sel(reg_y);
                    Gin     = 1'b1;
                    AluOp   = opcode;
                    Tstep_d = T3;
                end else begin
                    Tstep_d = T0;
                end
            end
            T3: begin
                if (is_alu) begin
                    Gout = 1'b1;
                    Rin  = sel(reg_x);
                    Done = 1'b1;
                end
                Tstep_d = T0;
            end
            default: Tstep_d = T0;
        endcase

        // Reset silences every output in the same cycle so an aborted instruction never writes back.
        if (Reset) begin
            Tstep_d = T0;
            IRin    = 1'b0;
            Rout    = 8'b0;
            Gout    = 1'b0;
            DINout  = 1'b0;
            Rin     = 8'b0;
            Ain     = 1'b0;
            Gin     = 1'b0;
            AluOp   = 3'b000;
            Done    = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) Tstep_q <= T0;
        else       Tstep_q <= Tstep_d;
    end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the per-cycle expected outputs of each
// instruction into a queue; a negedge monitor pops and compares them against the DUT.
module tb_control_unit;
    logic       Clock = 1'b0;
    logic       Reset, Run;
    logic [8:0] IR;
    logic       IRin, Gout, DINout, Ain, Gin, Done;
    logic [7:0] Rout, Rin;
    logic [2:0] AluOp;

    typedef struct packed {
        logic       irin;
        logic [7:0] rout;
        logic       gout;
        logic       dinout;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic [2:0] aluop;
        logic       done;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    control_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .Run   (Run),
        .IR    (IR),
        .IRin  (IRin),
        .Rout  (Rout),
        .Gout  (Gout),
        .DINout(DINout),
        .Rin   (Rin),
        .Ain   (Ain),
        .Gin   (Gin),
        .AluOp (AluOp),
        .Done  (Done)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] onehot(input int k);
        logic [7:0] top;
        top = 8'b1000_0000;
        return top >> k;
    endfunction

    // Monitor: one expected record per clock cycle, plus structural bus rules every cycle.
    always @(negedge Clock) begin
        out_t got, e;
        int   srcs;
        got = '{IRin, Rout, Gout, DINout, Rin, Ain, Gin, AluOp, Done};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d IR=%b got irin=%b rout=%b gout=%b din=%b rin=%b ain=%b gin=%b op=%b done=%b exp irin=%b rout=%b gout=%b din=%b rin=%b ain=%b gin=%b op=%b done=%b",
                         cyc, IR, got.irin, got.rout, got.gout, got.dinout, got.rin, got.ain, got.gin, got.aluop, got.done,
                         e.irin, e.rout, e.gout, e.dinout, e.rin, e.ain, e.gin, e.aluop, e.done);
            end else begin
                $display("cyc=%0d IR=%b irin=%b rout=%b gout=%b din=%b rin=%b ain=%b gin=%b op=%b done=%b ok",
                         cyc, IR, got.irin, got.rout, got.gout, got.dinout, got.rin, got.ain, got.gin, got.aluop, got.done);
            end
            srcs = int'(Rout != 8'b0) + int'(Gout) + int'(DINout);
            checks++;
            if (srcs > 1 || $countones(Rout) > 1 || $countones(Rin) > 1) begin
                errors++;
                $display("FAIL bus_excl cyc=%0d got sources=%0d rout=%b rin=%b exp sources<=1 popcounts<=1",
                         cyc, srcs, Rout, Rin);
            end
        end
        cyc++;
    end

    task automatic drive(input logic run, input logic [8:0] ir, input logic rst, input out_t e);
        @(posedge Clock);
        #1;
        Run   = run;
        IR    = ir;
        Reset = rst;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 9'($urandom), 1'b0, '0);
    endtask

    // Issue one instruction; abort_step>0 replaces that timestep with rst_len reset cycles.
    task automatic issue(input logic [8:0] ir, input bit hold_run, input int abort_step, input int rst_len);
        out_t recs[4];
        int   n;
        int   op, x, y;
        op = int'(ir[8:6]);
        x  = int'(ir[5:3]);
        y  = int'(ir[2:0]);
        for (int i = 0; i < 4; i++) recs[i] = '0;
        recs[0].irin = 1'b1;
        if (op == 0) begin
            n = 2;
            recs[1].rout = onehot(y);
            recs[1].rin  = onehot(x);
            recs[1].done = 1'b1;
        end else if (op == 1) begin
            n = 2;
            recs[1].dinout = 1'b1;
            recs[1].rin    = onehot(x);
            recs[1].done   = 1'b1;
        end else begin
            n = 4;
            recs[1].rout  = onehot(x);
            recs[1].ain   = 1'b1;
            recs[2].rout  = onehot(y);
            recs[2].gin   = 1'b1;
            recs[2].aluop = ir[8:6];
            recs[3].gout  = 1'b1;
            recs[3].rin   = onehot(x);
            recs[3].done  = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            logic run_v;
            run_v = (i == 0 || hold_run) ? 1'b1 : 1'($urandom);
            if (abort_step != 0 && i == abort_step) begin
                for (int r = 0; r < rst_len; r++) drive(run_v, ir, 1'b1, '0);
                return;
            end
            drive(run_v, ir, 1'b0, recs[i]);
        end
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b0;
        IR    = 9'b0;
        drive(1'b0, 9'b0, 1'b1, '0);
        drive(1'b0, 9'b0, 1'b1, '0);

        idle(5);
        issue(9'b000_010_101, 1'b0, 0, 0);   // mv R2,R5
        idle(1);
        issue(9'b001_111_000, 1'b0, 0, 0);   // mvi R7
        idle(1);
        issue(9'b011_000_001, 1'b0, 0, 0);   // sub R0,R1
        idle(1);
        issue(9'b010_011_011, 1'b0, 2, 2);   // add R3,R3 aborted in T2
        idle(2);
        issue(9'b000_011_011, 1'b1, 0, 0);   // mv R3,R3 then add, Run held high
        issue(9'b010_001_110, 1'b1, 0, 0);
        idle(1);

        for (int k = 0; k < 300; k++) begin
            logic [8:0] ir;
            int         ab, maxs;
            ir   = 9'($urandom);
            maxs = (ir[8:7] == 2'b00) ? 1 : 3;
            ab   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, maxs)) : 0;
            issue(ir, 1'b0, ab, int'($urandom_range(1, 2)));
            idle(int'($urandom_range(0, 2)));
        end

        @(posedge Clock);
        @(posedge Clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
